// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA context sequencer: widths, the kernel
// configuration word layout and the sequencer state encoding.
package cgra_pkg;

  localparam int IMEM_N_LINES_LOG2   = 4;
  localparam int IMEM_N_LINES        = 1 << IMEM_N_LINES_LOG2;
  localparam int KER_CONF_N_REG_LOG2 = 4;
  localparam int KMEM_WIDTH          = 32;

  // Kernel config word: start line in the low field, last offset right above it.
  localparam int KCONF_START_LSB = 0;
  localparam int KCONF_LAST_LSB  = KCONF_START_LSB + IMEM_N_LINES_LOG2;
  localparam int KCONF_UPPER_LSB = KCONF_LAST_LSB + IMEM_N_LINES_LOG2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/cgra_ctx_sequencer.sv
// Walks the instruction lines of one kernel: reads its config word, requests
// each line from the context memory and tracks the single line in flight.
module cgra_ctx_sequencer
  import cgra_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [KER_CONF_N_REG_LOG2-1:0] ker_id_i,
  output logic [KER_CONF_N_REG_LOG2-1:0] kmem_radd_o,
  input  logic [KMEM_WIDTH-1:0]          kmem_rdata_i,
  output logic                           rcs_conf_req_o,
  output logic [IMEM_N_LINES_LOG2-1:0]   imem_radd_o,
  input  logic                           imem_gnt_i,
  input  logic                           imem_rvalid_i,
  output logic                           busy_o,
  output logic                           line_valid_o,
  output logic [IMEM_N_LINES_LOG2-1:0]   line_idx_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam logic [IMEM_N_LINES_LOG2-1:0] LINE_ONE = 1;

  seq_state_e                       state_q, state_d;
  logic [KER_CONF_N_REG_LOG2-1:0]   kerId_q, kerId_d;
  logic [IMEM_N_LINES_LOG2-1:0]     pc_q, pc_d;
  logic [IMEM_N_LINES_LOG2-1:0]     remaining_q, remaining_d;
  logic                             inFlightValid_q, inFlightValid_d;
  logic [IMEM_N_LINES_LOG2-1:0]     inFlightAddr_q, inFlightAddr_d;
  logic                             err_d;

  logic                             busy_q, req_q, done_q, err_q;
  logic [IMEM_N_LINES_LOG2-1:0]     imemAdd_q;
  logic [KER_CONF_N_REG_LOG2-1:0]   kmemAdd_q;

  logic [IMEM_N_LINES_LOG2-1:0]     cfgStart, cfgLast;
  logic                             grant, lineValid;
  logic                             unusedKmemBits;

  assign cfgStart       = kmem_rdata_i[KCONF_START_LSB +: IMEM_N_LINES_LOG2];
  assign cfgLast        = kmem_rdata_i[KCONF_LAST_LSB +: IMEM_N_LINES_LOG2];
  assign unusedKmemBits = ^kmem_rdata_i[KMEM_WIDTH-1:KCONF_UPPER_LSB];

  // A grant only counts while this block is actually requesting.
  assign grant     = (state_q == FETCH) && imem_gnt_i;
  assign lineValid = imem_rvalid_i && inFlightValid_q;

  always_comb begin
    state_d         = state_q;
    kerId_d         = kerId_q;
    pc_d            = pc_q;
    remaining_d     = remaining_q;
    inFlightValid_d = inFlightValid_q;
    inFlightAddr_d  = inFlightAddr_q;
    err_d           = 1'b0;

    if (grant) begin
      inFlightValid_d = 1'b1;
      inFlightAddr_d  = pc_q;
    end else if (imem_rvalid_i) begin
      inFlightValid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ker_id_i != '0) begin
            kerId_d = ker_id_i;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        pc_d        = cfgStart;
        remaining_d = cfgLast;
        state_d     = FETCH;
      end
      FETCH: begin
        if (grant) begin
          pc_d = pc_q + LINE_ONE;
          if (remaining_q == '0) begin
            state_d = DRAIN;
          end else begin
            remaining_d = remaining_q - LINE_ONE;
          end
        end
      end
      DRAIN: begin
        if (lineValid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      kerId_q         <= '0;
      pc_q            <= '0;
      remaining_q     <= '0;
      inFlightValid_q <= 1'b0;
      inFlightAddr_q  <= '0;
      busy_q          <= 1'b0;
      req_q           <= 1'b0;
      imemAdd_q       <= '0;
      kmemAdd_q       <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      kerId_q         <= kerId_d;
      pc_q            <= pc_d;
      remaining_q     <= remaining_d;
      inFlightValid_q <= inFlightValid_d;
      inFlightAddr_q  <= inFlightAddr_d;
      busy_q          <= (state_d != IDLE);
      req_q           <= (state_d == FETCH);
      imemAdd_q       <= (state_d == FETCH) ? pc_d : '0;
      kmemAdd_q       <= (state_d == LOAD) ? kerId_d : '0;
      done_q          <= (state_d == DONE);
      err_q           <= err_d;
    end
  end

  assign busy_o         = busy_q;
  assign rcs_conf_req_o = req_q;
  assign imem_radd_o    = imemAdd_q;
  assign kmem_radd_o    = kmemAdd_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign line_valid_o   = lineValid;
  assign line_idx_o     = inFlightAddr_q;

endmodule

// File: tb/tb_cgra_ctx_sequencer.sv
// Directed cycle-by-cycle bench for cgra_ctx_sequencer: a table of per-cycle
// inputs and expected outputs, plus a hand-written mid-sequence reset.
module tb_cgra_ctx_sequencer;
  import cgra_pkg::*;

  typedef struct {
    logic                           start;
    logic [KER_CONF_N_REG_LOG2-1:0] kerId;
    logic                           gnt;
    logic                           spur;
    logic                           busy;
    logic                           req;
    logic [IMEM_N_LINES_LOG2-1:0]   imemAdd;
    logic [KER_CONF_N_REG_LOG2-1:0] kmemAdd;
    logic                           lineValid;
    logic [IMEM_N_LINES_LOG2-1:0]   lineIdx;
    logic                           done;
    logic                           err;
  } vec_t;

  logic                           clk = 1'b0;
  logic                           rstN;
  logic                           startI;
  logic [KER_CONF_N_REG_LOG2-1:0] kerId;
  logic [KER_CONF_N_REG_LOG2-1:0] kmemRadd;
  logic [KMEM_WIDTH-1:0]          kmemRdata;
  logic                           reqO;
  logic [IMEM_N_LINES_LOG2-1:0]   imemRadd;
  logic                           gnt;
  logic                           rvalid;
  logic                           busyO;
  logic                           lineValidO;
  logic [IMEM_N_LINES_LOG2-1:0]   lineIdxO;
  logic                           doneO;
  logic                           errO;

  logic [KMEM_WIDTH-1:0] kmem [0:(1<<KER_CONF_N_REG_LOG2)-1];
  logic grantPrev;
  int   checkCount = 0;
  int   passCount  = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  assign kmemRdata = kmem[kmemRadd];

  cgra_ctx_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .start_i        (startI),
    .ker_id_i       (kerId),
    .kmem_radd_o    (kmemRadd),
    .kmem_rdata_i   (kmemRdata),
    .rcs_conf_req_o (reqO),
    .imem_radd_o    (imemRadd),
    .imem_gnt_i     (gnt),
    .imem_rvalid_i  (rvalid),
    .busy_o         (busyO),
    .line_valid_o   (lineValidO),
    .line_idx_o     (lineIdxO),
    .done_o         (doneO),
    .err_o          (errO)
  );

  function automatic vec_t mk(input int st, input int id, input int g, input int sp,
                              input int bz, input int rq, input int ia, input int ka,
                              input int lv, input int li, input int dn, input int er);
    vec_t v;
    v.start     = st[0];
    v.kerId     = id[KER_CONF_N_REG_LOG2-1:0];
    v.gnt       = g[0];
    v.spur      = sp[0];
    v.busy      = bz[0];
    v.req       = rq[0];
    v.imemAdd   = ia[IMEM_N_LINES_LOG2-1:0];
    v.kmemAdd   = ka[KER_CONF_N_REG_LOG2-1:0];
    v.lineValid = lv[0];
    v.lineIdx   = li[IMEM_N_LINES_LOG2-1:0];
    v.done      = dn[0];
    v.err       = er[0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s at step %0d: got %0d, expected %0d", name, idx, act, exp);
    end else begin
      passCount++;
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample mid-cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    startI = v.start;
    kerId  = v.kerId;
    gnt    = v.gnt;
    rvalid = grantPrev | v.spur;
    #3;
    checkOutput("busy_o",         idx, 32'(busyO),      32'(v.busy));
    checkOutput("rcs_conf_req_o", idx, 32'(reqO),       32'(v.req));
    checkOutput("imem_radd_o",    idx, 32'(imemRadd),   32'(v.imemAdd));
    checkOutput("kmem_radd_o",    idx, 32'(kmemRadd),   32'(v.kmemAdd));
    checkOutput("line_valid_o",   idx, 32'(lineValidO), 32'(v.lineValid));
    if (v.lineValid) begin
      checkOutput("line_idx_o",   idx, 32'(lineIdxO),   32'(v.lineIdx));
    end
    checkOutput("done_o",         idx, 32'(doneO),      32'(v.done));
    checkOutput("err_o",          idx, 32'(errO),       32'(v.err));
    grantPrev = reqO & gnt;
  endtask

  initial begin
    for (int i = 0; i < (1<<KER_CONF_N_REG_LOG2); i++) kmem[i] = '0;
    kmem[3] = 32'h0000_0025;  // start 5, last offset 2
    kmem[4] = 32'h0000_001F;  // start 15, last offset 1 (wraps)
    kmem[5] = 32'h0000_0009;  // start 9, single line

    rstN = 1'b0; startI = 1'b0; kerId = '0; gnt = 1'b0; rvalid = 1'b0; grantPrev = 1'b0;
    #12;
    checkOutput("reset busy_o",       -1, 32'(busyO),      32'd0);
    checkOutput("reset req",          -1, 32'(reqO),       32'd0);
    checkOutput("reset imem_radd_o",  -1, 32'(imemRadd),   32'd0);
    checkOutput("reset kmem_radd_o",  -1, 32'(kmemRadd),   32'd0);
    checkOutput("reset line_valid_o", -1, 32'(lineValidO), 32'd0);
    checkOutput("reset line_idx_o",   -1, 32'(lineIdxO),   32'd0);
    checkOutput("reset done_o",       -1, 32'(doneO),      32'd0);
    checkOutput("reset err_o",        -1, 32'(errO),       32'd0);
    rstN = 1'b1;

    //            st id g sp  bz rq ia ka lv li dn er
    // kernel 3, always granted: lines 5,6,7
    tbl.push_back(mk(1, 3, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 6, 0, 1, 5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 7, 0, 1, 6, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 1, 7, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    // kernel 3, grant withheld two cycles on line 6
    tbl.push_back(mk(1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 1, 6, 0, 1, 5, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 7, 0, 1, 6, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 7, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    // kernel 4: line 15 wraps to line 0
    tbl.push_back(mk(1, 4, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1,15, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 0, 0, 1,15, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    // kernel id 0 is rejected with a single err_o pulse
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    // start pulses during FETCH are ignored
    tbl.push_back(mk(1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  1, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0,  1, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 6, 0, 1, 5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 7, 0, 1, 6, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 7, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    // spurious rvalid while idle
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    // kernel 5, single line: done_o four cycles after the start cycle
    tbl.push_back(mk(1, 5, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 1, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 9, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) applyStimulus(tbl[i], i);

    // Reset asserted mid-FETCH with a line in flight.
    $display("[TB] mid-sequence reset");
    applyStimulus(mk(1, 3, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0), 100);
    applyStimulus(mk(0, 0, 1, 0,  1, 0, 0, 3, 0, 0, 0, 0), 101);
    applyStimulus(mk(0, 0, 1, 0,  1, 1, 5, 0, 0, 0, 0, 0), 102);
    applyStimulus(mk(0, 0, 1, 0,  1, 1, 6, 0, 1, 5, 0, 0), 103);
    @(posedge clk);
    #1;
    gnt = 1'b1; rvalid = 1'b1; rstN = 1'b0;
    #2;
    checkOutput("rst busy_o",       104, 32'(busyO),      32'd0);
    checkOutput("rst req",          104, 32'(reqO),       32'd0);
    checkOutput("rst imem_radd_o",  104, 32'(imemRadd),   32'd0);
    checkOutput("rst kmem_radd_o",  104, 32'(kmemRadd),   32'd0);
    checkOutput("rst line_valid_o", 104, 32'(lineValidO), 32'd0);
    checkOutput("rst done_o",       104, 32'(doneO),      32'd0);
    checkOutput("rst err_o",        104, 32'(errO),       32'd0);
    grantPrev = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1; gnt = 1'b0;
    #2;
    checkOutput("post-rst line_valid_o", 105, 32'(lineValidO), 32'd0);
    checkOutput("post-rst done_o",       105, 32'(doneO),      32'd0);
    checkOutput("post-rst busy_o",       105, 32'(busyO),      32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0), 106 + i);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
